pc_unit: RTL and testbench

//  Program-counter stage for the single-cycle MIPS32 core; consumes PCSrc from the control decoder.

---
 rtl/pc_unit_if.sv | 34 +++
 rtl/pc_unit.sv | 106 ++++++++++
 tb/tb_pc_unit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/pc_unit_if.sv
// Decoder <-> PC stage bus: next-PC select, operands, interrupt line and PC-derived results.
// AlignErr is present only when PC_ALIGN_CHECK_EN is defined.
interface pc_unit_if;
    logic [2:0]  PCSrc;
    logic        ALUOut0;
    logic [31:0] Instruction;
    logic [31:0] DataBusA;
    logic        Hold;
    logic        IRQ;
    logic [31:0] PC;
    logic [31:0] PC_plus4;
    logic [31:0] LinkAddr;
    logic        ker;
    logic        IRQ_pend;
`ifdef PC_ALIGN_CHECK_EN
    logic        AlignErr;
`endif

    modport master (
        output PCSrc, ALUOut0, Instruction, DataBusA, Hold, IRQ,
`ifdef PC_ALIGN_CHECK_EN
        input  AlignErr,
`endif
        input  PC, PC_plus4, LinkAddr, ker, IRQ_pend
    );

    modport slave (
        input  PCSrc, ALUOut0, Instruction, DataBusA, Hold, IRQ,
`ifdef PC_ALIGN_CHECK_EN
        output AlignErr,
`endif
        output PC, PC_plus4, LinkAddr, ker, IRQ_pend
    );
endinterface

// File: rtl/pc_unit.sv
// Program-counter stage of the single-cycle MIPS32 core: next-PC select, link address, IRQ latch.
// Optional macro PC_ALIGN_CHECK_EN: a misaligned jr/jalr target traps to ILLOP_VEC and pulses AlignErr.
module pc_unit #(
    parameter logic [31:0] RESET_VEC = 32'h8000_0000,
    parameter logic [31:0] ILLOP_VEC = 32'h8000_0004,
    parameter logic [31:0] XADR_VEC  = 32'h8000_0008
) (
    input logic   clk,
    input logic   reset,
    pc_unit_if.slave bus
);
    logic [31:0] pc_q, pc_d;
    logic        irq_smp_q, irq_smp_d;
    logic        irq_pend_q, irq_pend_d;
    logic [31:0] seq;
    logic [31:0] br_off;
    logic [31:0] jr_tgt;
    logic [31:0] next_pc;
    logic        irq_rise;
    logic        irq_clr;
`ifdef PC_ALIGN_CHECK_EN
    logic        misaligned;
    logic        align_err_q, align_err_d;
`else
    logic        unused_bits;
    assign unused_bits = ^{bus.DataBusA[1:0], bus.Instruction[31:26]};
`endif

    // Next-state computation for PC, IRQ sample/pending and alignment flag
    always_comb begin
        // PC[31] is carried separately so arithmetic wraps inside PC[30:0]
        seq      = {pc_q[31], pc_q[30:0] + 31'd4};
        br_off   = {{14{bus.Instruction[15]}}, bus.Instruction[15:0], 2'b00};
        jr_tgt   = {pc_q[31] & bus.DataBusA[31], bus.DataBusA[30:2], 2'b00};
`ifdef PC_ALIGN_CHECK_EN
        misaligned = (bus.DataBusA[1:0] != 2'b00);
`endif
        case (bus.PCSrc)
            3'd0: next_pc = seq;
            3'd1: begin
                if (bus.ALUOut0) begin
                    next_pc = {pc_q[31], seq[30:0] + br_off[30:0]};
                end else begin
                    next_pc = seq;
                end
            end
            3'd2: next_pc = {pc_q[31:28], bus.Instruction[25:0], 2'b00};
            3'd3: begin
`ifdef PC_ALIGN_CHECK_EN
                if (misaligned) begin
                    next_pc = ILLOP_VEC;
                end else begin
                    next_pc = jr_tgt;
                end
`else
                next_pc = jr_tgt;
`endif
            end
            3'd4:    next_pc = XADR_VEC;
            default: next_pc = ILLOP_VEC;
        endcase

        if (bus.Hold) begin
            pc_d = pc_q;
        end else begin
            pc_d = next_pc;
        end

        // A fresh rising edge beats a same-cycle clear
        irq_smp_d  = bus.IRQ;
        irq_rise   = bus.IRQ & ~irq_smp_q;
        irq_clr    = (bus.PCSrc == 3'd4) & ~bus.Hold;
        irq_pend_d = irq_rise | (irq_pend_q & ~irq_clr);
`ifdef PC_ALIGN_CHECK_EN
        align_err_d = ~bus.Hold & (bus.PCSrc == 3'd3) & misaligned;
`endif
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_VEC;
            irq_smp_q   <= 1'b0;
            irq_pend_q  <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            align_err_q <= 1'b0;
`endif
        end else begin
            pc_q        <= pc_d;
            irq_smp_q   <= irq_smp_d;
            irq_pend_q  <= irq_pend_d;
`ifdef PC_ALIGN_CHECK_EN
            align_err_q <= align_err_d;
`endif
        end
    end

    assign bus.PC       = pc_q;
    assign bus.PC_plus4 = seq;
    assign bus.LinkAddr = (bus.PCSrc == 3'd4) ? pc_q : seq;
    assign bus.ker      = pc_q[31];
    assign bus.IRQ_pend = irq_pend_q;
`ifdef PC_ALIGN_CHECK_EN
    assign bus.AlignErr = align_err_q;
`endif
endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios followed by random cycles against a reference model.
module tb_pc_unit;
    logic clk;
    logic reset;
    int   chk_cnt;
    int   pass_cnt;

    pc_unit_if bus ();

    pc_unit u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference state
    logic [31:0] m_pc;
    logic        m_pend;
    logic        m_irq_prev;
    logic        m_aerr;

    task automatic check32(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    function automatic logic [31:0] m_seq(input logic [31:0] pc);
        return (pc & 32'h8000_0000) | ((pc + 32'd4) & 32'h7FFF_FFFF);
    endfunction

    function automatic logic [31:0] m_next(input logic [31:0] pc, input logic [2:0] src,
                                           input logic alu, input logic [31:0] instr,
                                           input logic [31:0] dba);
        int off;
        off = int'($signed(instr[15:0])) * 4;
        case (src)
            3'd0: return m_seq(pc);
            3'd1: return alu ? ((pc & 32'h8000_0000) | ((pc + 32'd4 + 32'(off)) & 32'h7FFF_FFFF))
                             : m_seq(pc);
            3'd2: return (pc & 32'hF000_0000) | {4'h0, instr[25:0], 2'b00};
            3'd3: begin
`ifdef PC_ALIGN_CHECK_EN
                if (dba[1:0] != 2'b00) return 32'h8000_0004;
`endif
                return (pc & dba & 32'h8000_0000) | (dba & 32'h7FFF_FFFC);
            end
            3'd4: return 32'h8000_0008;
            default: return 32'h8000_0004;
        endcase
    endfunction

    // One clock: drive at negedge, check combinational outputs, advance model, check registers
    task automatic step(input logic rst, input logic [2:0] src, input logic alu,
                        input logic [31:0] instr, input logic [31:0] dba,
                        input logic hold, input logic irq);
        logic rise;
        logic was_user;
        reset           = rst;
        bus.PCSrc       = src;
        bus.ALUOut0     = alu;
        bus.Instruction = instr;
        bus.DataBusA    = dba;
        bus.Hold        = hold;
        bus.IRQ         = irq;
        #1;
        if (!rst) begin
            check32("plus4", bus.PC_plus4, m_seq(m_pc));
            check32("link", bus.LinkAddr, (src == 3'd4) ? m_pc : m_seq(m_pc));
            check32("ker", {31'd0, bus.ker}, {31'd0, m_pc[31]});
        end
        was_user = (m_pc[31] === 1'b0);
        @(posedge clk);
        if (rst) begin
            m_pc = 32'h8000_0000; m_pend = 1'b0; m_irq_prev = 1'b0; m_aerr = 1'b0;
        end else begin
            rise       = irq & ~m_irq_prev;
            m_irq_prev = irq;
            m_aerr     = 1'b0;
            if (!hold) begin
`ifdef PC_ALIGN_CHECK_EN
                m_aerr = (src == 3'd3) && (dba[1:0] != 2'b00);
`endif
                m_pc = m_next(m_pc, src, alu, instr, dba);
            end
            if (rise) m_pend = 1'b1;
            else if (!hold && src == 3'd4) m_pend = 1'b0;
        end
        @(negedge clk);
        check32("pc", bus.PC, m_pc);
        check32("irq_pend", {31'd0, bus.IRQ_pend}, {31'd0, m_pend});
`ifdef PC_ALIGN_CHECK_EN
        check32("align_err", {31'd0, bus.AlignErr}, {31'd0, m_aerr});
`endif
        if (!rst && was_user && (src <= 3'd2 || (src == 3'd3 && dba[1:0] == 2'b00)))
            check32("no_kernel_entry", {31'd0, bus.PC[31]}, 32'd0);
    endtask

    initial begin
        logic irq_r;
        chk_cnt = 0; pass_cnt = 0;
        m_pc = 32'h0; m_pend = 1'b0; m_irq_prev = 1'b0; m_aerr = 1'b0;
        reset = 1'b1;
        bus.PCSrc = 3'd0; bus.ALUOut0 = 1'b0; bus.Instruction = 32'd0;
        bus.DataBusA = 32'd0; bus.Hold = 1'b0; bus.IRQ = 1'b0;
        @(negedge clk);

        // reset then sequential fetch
        step(1'b1, 3'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 3'd0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        check32("t1_reset_pc", bus.PC, 32'h8000_0000);
        check32("t1_reset_pend", {31'd0, bus.IRQ_pend}, 32'd0);
        step(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        check32("t1_seq1", bus.PC, 32'h8000_0004);
        step(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        check32("t1_seq2", bus.PC, 32'h8000_0008);
        step(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        check32("t1_seq3", bus.PC, 32'h8000_000C);

        // branch with offset -1 word, taken and not taken
        step(1'b0, 3'd3, 1'b0, 32'd0, 32'h0000_0100, 1'b0, 1'b0);
        check32("t2_jr", bus.PC, 32'h0000_0100);
        step(1'b0, 3'd1, 1'b1, 32'h0000_FFFF, 32'd0, 1'b0, 1'b0);
        check32("t2_taken", bus.PC, 32'h0000_0100);
        step(1'b0, 3'd1, 1'b0, 32'h0000_FFFF, 32'd0, 1'b0, 1'b0);
        check32("t2_not_taken", bus.PC, 32'h0000_0104);

        // jr leaves kernel but cannot enter it
        step(1'b0, 3'd4, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 3'd2, 1'b0, 32'h0000_0010, 32'd0, 1'b0, 1'b0);
        check32("t3_j", bus.PC, 32'h8000_0040);
        step(1'b0, 3'd3, 1'b0, 32'd0, 32'h0040_0000, 1'b0, 1'b0);
        check32("t3_jr_user", bus.PC, 32'h0040_0000);
        check32("t3_ker", {31'd0, bus.ker}, 32'd0);
        step(1'b0, 3'd3, 1'b0, 32'd0, 32'h8000_0000, 1'b0, 1'b0);
        check32("t3_jr_nokernel", bus.PC, 32'h0000_0000);

        // interrupt latch and service
        step(1'b0, 3'd2, 1'b0, 32'h0010_0004, 32'd0, 1'b0, 1'b0);
        check32("t4_pc", bus.PC, 32'h0040_0010);
        step(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        check32("t4_pend_set", {31'd0, bus.IRQ_pend}, 32'd1);
        bus.PCSrc = 3'd4; #1;
        check32("t4_link", bus.LinkAddr, 32'h0040_0010);
        step(1'b0, 3'd4, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        check32("t4_xadr", bus.PC, 32'h8000_0008);
        check32("t4_pend_clr", {31'd0, bus.IRQ_pend}, 32'd0);
        step(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        check32("t4_no_reset", {31'd0, bus.IRQ_pend}, 32'd0);

        // hold freezes PC and the clear, but not the IRQ sampler
        step(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 3'd2, 1'b0, 32'h0123_4567, 32'd0, 1'b1, 1'b1);
        check32("t5_hold_pc", bus.PC, 32'h8000_000C);
        check32("t5_hold_pend", {31'd0, bus.IRQ_pend}, 32'd1);
        step(1'b0, 3'd4, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        check32("t5_hold_noclr", {31'd0, bus.IRQ_pend}, 32'd1);

        // misaligned jr target
        step(1'b0, 3'd3, 1'b0, 32'd0, 32'h0040_0002, 1'b0, 1'b1);
`ifdef PC_ALIGN_CHECK_EN
        check32("t6_trap", bus.PC, 32'h8000_0004);
        check32("t6_aerr", {31'd0, bus.AlignErr}, 32'd1);
        step(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        check32("t6_aerr_pulse", {31'd0, bus.AlignErr}, 32'd0);
`else
        check32("t6_forced", bus.PC, 32'h0040_0000);
`endif

        // random traffic
        irq_r = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 2) == 0) irq_r = ~irq_r;
            step(($urandom_range(0, 99) == 0), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), $urandom, $urandom,
                 ($urandom_range(0, 3) == 0), irq_r);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
